// File: rtl/riscv_pkg.sv
// Shared fetch-path definitions: datapath widths, the sequential PC
// increment, the FIFO entry type and a PC word-alignment helper.
package riscv_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned XLEN   = 32;

  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of fetch_entry_t with a head that is visible combinationally.
// Ports:
//   i_clk, i_reset    clock, asynchronous active-high reset
//   i_push, i_data    enqueue an entry
//   i_pop             dequeue the head (ignored when empty)
//   i_flush           drop all entries; wins over push and pop
//   o_head            current head entry
//   o_count           number of valid entries (0..DEPTH)
//   o_empty, o_full   occupancy flags
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_push,
  input  fetch_entry_t           i_data,
  input  logic                   i_pop,
  input  logic                   i_flush,
  output fetch_entry_t           o_head,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_empty,
  output logic                   o_full
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign w_do_pop  = i_pop && !o_empty;
  // A push into a full FIFO is only accepted when the head leaves the same cycle.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Pipelined instruction fetch stage. Owns the sequential fetch PC, issues
// word requests to instruction memory under a credit limit of DEPTH
// (FIFO entries + outstanding requests), buffers in-order responses with
// their PCs and hands them to the core over a valid/ready handshake.
// A redirect flushes the FIFO and marks every in-flight response for discard.
// Ports:
//   clk, reset                         clock, asynchronous active-high reset
//   imem_req_valid/addr/ready          request channel to instruction memory
//   imem_rsp_valid/data                in-order response channel
//   redirect_valid/pc                  taken branch/jump from the core
//   inst_valid/data/pc, inst_ready     instruction channel to the core
// Optional (macro FETCH_PERF_EN):
//   perf_stall_cnt                     cycles with no instruction offered
//   perf_flush_cnt                     entries/responses killed by redirects
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_rsp_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_discard;

  logic [CW-1:0] w_fifo_count;
  logic          w_fifo_empty;
  logic          w_fifo_full;
  logic          w_unused_full;
  logic [CW:0]   w_credit_used;
  logic          w_req_fire;
  logic          w_rsp_valid;
  logic          w_rsp_keep;
  logic          w_rsp_drop;
  logic          w_pop;
  logic [31:0]   w_target_pc;
  fetch_entry_t  w_push_entry;
  fetch_entry_t  w_head;

  assign w_credit_used  = {1'b0, w_fifo_count} + {1'b0, r_outstanding};
  assign imem_req_valid = !reset && !redirect_valid && (w_credit_used < (CW+1)'(DEPTH));
  assign imem_req_addr  = r_fetch_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  // Responses with nothing outstanding cannot belong to any request; ignore them.
  assign w_rsp_valid  = imem_rsp_valid && (r_outstanding != '0);
  assign w_rsp_drop   = w_rsp_valid && (r_discard != '0);
  assign w_rsp_keep   = w_rsp_valid && (r_discard == '0);
  assign w_pop        = inst_valid && inst_ready;
  assign w_target_pc  = align_pc(redirect_pc);
  assign w_push_entry = '{pc: r_rsp_pc, inst: imem_rsp_data};
  assign w_unused_full = w_fifo_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else if (redirect_valid) begin
      // No request fires this cycle; whatever is still in flight after the
      // response consumed now (if any) is stale, whether or not it already was.
      r_fetch_pc    <= w_target_pc;
      r_rsp_pc      <= w_target_pc;
      r_outstanding <= r_outstanding - CW'(w_rsp_valid);
      r_discard     <= r_outstanding - CW'(w_rsp_valid);
    end else begin
      if (w_req_fire) r_fetch_pc <= r_fetch_pc + PC_STEP;
      if (w_rsp_keep) r_rsp_pc   <= r_rsp_pc + PC_STEP;
      if (w_rsp_drop) r_discard  <= r_discard - CW'(1);
      r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(w_rsp_valid);
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_reset (reset),
    .i_push  (w_rsp_keep),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .o_head  (w_head),
    .o_count (w_fifo_count),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

  assign inst_valid = !w_fifo_empty;
  assign inst_data  = w_head.inst;
  assign inst_pc    = w_head.pc;

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_flush;
  logic [CW:0] w_killed;
  logic [32:0] w_flush_sum;

  // Killed work = buffered entries plus live (not already stale) responses.
  assign w_killed    = {1'b0, w_fifo_count} + {1'b0, r_outstanding - r_discard};
  assign w_flush_sum = {1'b0, r_perf_flush} + 33'(w_killed);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf_stall <= '0;
      r_perf_flush <= '0;
    end else begin
      if (!inst_valid && (r_perf_stall != '1)) r_perf_stall <= r_perf_stall + 32'd1;
      if (redirect_valid) r_perf_flush <= w_flush_sum[32] ? '1 : w_flush_sum[31:0];
    end
  end

  assign perf_stall_cnt = r_perf_stall;
  assign perf_flush_cnt = r_perf_flush;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam int unsigned DEPTH   = 4;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data;
  logic        redirect_valid, inst_valid, inst_ready;
  logic [31:0] redirect_pc, inst_data, inst_pc;
  logic        wr_req_valid, wr_inst_valid;
  logic [31:0] wr_req_addr, wr_inst_data, wr_inst_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt, wr_perf_stall, wr_perf_flush;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc), .inst_ready(inst_ready)
`ifdef FETCH_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  // Second instance only exercises the PC wrap from a high reset address.
  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(WRAP_PC)) dut_wrap (
    .clk(clk), .reset(reset),
    .imem_req_valid(wr_req_valid), .imem_req_addr(wr_req_addr), .imem_req_ready(1'b1),
    .imem_rsp_valid(1'b0), .imem_rsp_data(32'h0),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .inst_valid(wr_inst_valid), .inst_data(wr_inst_data), .inst_pc(wr_inst_pc), .inst_ready(1'b0)
`ifdef FETCH_PERF_EN
    , .perf_stall_cnt(wr_perf_stall), .perf_flush_cnt(wr_perf_flush)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    int unsigned epoch;
    int unsigned due;
  } mreq_t;

  mreq_t       mem_q[$];   // accepted requests awaiting response (memory model)
  logic [31:0] fq[$];      // PCs the core should see, oldest first
  int unsigned tests, fails, cyc, epoch, last_due;
  int unsigned lat_min, lat_max, p_req_ready, p_inst_ready, p_redir;
  int unsigned acc_cnt, wrap_acc, first_valid_cyc, n;
  logic [31:0] m_fpc, stream_pc, last_pop_pc, last_pop_data, force_pc;
  bit          redir_out2, redir_rsp, force_redir, release_pending, pop_seen;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_knobs(input int unsigned lmin, input int unsigned lmax,
                           input int unsigned prr, input int unsigned pir, input int unsigned prd);
    lat_min = lmin; lat_max = lmax; p_req_ready = prr; p_inst_ready = pir; p_redir = prd;
  endtask

  task automatic idle_inputs();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
  endtask

  task automatic model_reset();
    mem_q.delete(); fq.delete();
    m_fpc = 32'h0; stream_pc = 32'h0; last_due = 0; cyc = 0; wrap_acc = 0;
    first_valid_cyc = 0; epoch++;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; idle_inputs(); model_reset();
    #2;
    check_eq("rst_req_valid", imem_req_valid, 0);
    check_eq("rst_inst_valid", inst_valid, 0);
    check_eq("rst_inst_data", inst_data, 0);
    check_eq("rst_inst_pc", inst_pc, 0);
    check_eq("rst_wrap_inst_valid", wr_inst_valid, 0);
    repeat (2) @(posedge clk);
    release_pending = 1'b1;
  endtask

  task automatic step();
    bit          rsp, redir, exp_rv, exp_acc, pop, wr_exp;
    int unsigned due;
    mreq_t       h;
    @(posedge clk); #1;
    if (release_pending) begin reset = 1'b0; release_pending = 1'b0; end
    cyc++;
    rsp = (mem_q.size() != 0) && (mem_q[0].due <= cyc);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mem_word(mem_q[0].addr) : 32'h0;
    imem_req_ready = ($urandom_range(99) < p_req_ready);
    inst_ready     = ($urandom_range(99) < p_inst_ready);
    redirect_valid = 1'b0;
    redirect_pc    = $urandom();
    if (force_redir) begin
      redirect_valid = 1'b1; redirect_pc = force_pc; force_redir = 1'b0;
    end else if (redir_out2) begin
      if (mem_q.size() == 2) begin redirect_valid = 1'b1; redirect_pc = 32'h100; redir_out2 = 1'b0; end
    end else if (redir_rsp) begin
      if (rsp && fq.size() != 0 && inst_ready) begin redirect_valid = 1'b1; redir_rsp = 1'b0; end
    end else if ($urandom_range(99) < p_redir) begin
      redirect_valid = 1'b1;
      if ($urandom_range(3) == 0) redirect_pc = 32'hFFFF_FFE0 | ($urandom() & 32'h1F);
    end
    redir = redirect_valid;

    @(negedge clk);
    exp_rv = ((fq.size() + mem_q.size()) < DEPTH) && !redir;
    check_eq("req_valid", imem_req_valid, exp_rv);
    if (exp_rv) check_eq("req_addr", imem_req_addr, m_fpc);
    check_eq("inst_valid", inst_valid, fq.size() != 0);
    if (fq.size() != 0) begin
      check_eq("inst_pc", inst_pc, fq[0]);
      check_eq("inst_data", inst_data, mem_word(fq[0]));
    end
    wr_exp = (wrap_acc < DEPTH);
    check_eq("wrap_req_valid", wr_req_valid, wr_exp);
    if (wr_exp) begin
      check_eq("wrap_req_addr", wr_req_addr, WRAP_PC + 32'(wrap_acc * 4));
      wrap_acc++;
    end
    if (first_valid_cyc == 0 && inst_valid) first_valid_cyc = cyc;

    // Advance the reference for the coming clock edge.
    exp_acc = exp_rv && imem_req_ready;
    pop     = (fq.size() != 0) && inst_ready && !redir;
    if (pop) begin
      check_eq("stream_pc", fq[0], stream_pc);
      last_pop_pc = inst_pc; last_pop_data = inst_data; pop_seen = 1'b1;
      void'(fq.pop_front());
      stream_pc += 32'd4;
    end
    if (rsp) begin
      h = mem_q.pop_front();
      if (!redir && h.epoch == epoch) fq.push_back(h.addr);
    end
    if (imem_req_valid && imem_req_ready) begin
      acc_cnt++;
      due = cyc + $urandom_range(lat_max, lat_min);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mem_q.push_back('{imem_req_addr, epoch, due});
    end
    if (exp_acc) m_fpc += 32'd4;
    if (redir) begin
      fq.delete(); epoch++;
      m_fpc = {redirect_pc[31:2], 2'b00};
      stream_pc = m_fpc;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0; fails = 0; epoch = 0; acc_cnt = 0;
    redir_out2 = 0; redir_rsp = 0; force_redir = 0; release_pending = 0; pop_seen = 0;
    force_pc = '0; last_pop_pc = '0; last_pop_data = '0;
    reset = 1'b1; idle_inputs();

    // Latency 1, always ready: one instruction per cycle from PC 0.
    set_knobs(1, 1, 100, 100, 0);
    do_reset();
    repeat (20) step();
    check_eq("first_inst_cycle", first_valid_cyc, 3);

    // Core stalled: credit limit caps accepted requests at DEPTH.
    set_knobs(1, 1, 100, 0, 0);
    do_reset();
    acc_cnt = 0;
    repeat (10) step();
    check_eq("accepts_stalled", acc_cnt, DEPTH);
    p_inst_ready = 100; pop_seen = 0;
    step();
    check_eq("drain_first_pc", last_pop_pc, 32'h0);
    repeat (10) step();

    // Latency 3: redirect with two requests in flight.
    set_knobs(3, 3, 100, 100, 0);
    do_reset();
    redir_out2 = 1'b1; n = 0;
    while (redir_out2 && n < 50) begin step(); n++; end
    check_eq("redir_out2_pending", redir_out2, 0);
    pop_seen = 0; n = 0;
    while (!pop_seen && n < 50) begin step(); n++; end
    check_eq("redir100_pc", last_pop_pc, 32'h100);
    check_eq("redir100_data", last_pop_data, mem_word(32'h100));

    // Unaligned redirect target.
    force_pc = 32'h203; force_redir = 1'b1;
    step();
    pop_seen = 0; n = 0;
    while (!pop_seen && n < 50) begin step(); n++; end
    check_eq("redir203_pc", last_pop_pc, 32'h200);

    // Redirect coinciding with a response and a pop.
    set_knobs(1, 2, 100, 100, 0);
    redir_rsp = 1'b1; n = 0;
    while (redir_rsp && n < 200) begin step(); n++; end
    check_eq("redir_rsp_pending", redir_rsp, 0);
    repeat (20) step();

    // Randomised traffic.
    set_knobs(1, 4, 70, 70, 5);
    repeat (3000) step();

    // Asynchronous reset with entries buffered.
    set_knobs(1, 2, 100, 0, 0);
    repeat (8) step();
    @(posedge clk); #2;
    check_eq("pre_rst_inst_valid", inst_valid, 1);
    #1 reset = 1'b1;
    #1;
    check_eq("async_rst_inst_valid", inst_valid, 0);
    check_eq("async_rst_req_valid", imem_req_valid, 0);
    idle_inputs(); model_reset();
    repeat (2) @(posedge clk);
    release_pending = 1'b1;
    set_knobs(1, 3, 80, 80, 5);
    repeat (300) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
